game_flow_ctrl: RTL
===================

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 65_000_000, meaning the pclk frequency and the one-second tick period in cycles.
REQ-002 The block SHALL have parameter GAME_TIME, default 60, meaning the game length in seconds.
REQ-003 The block SHALL have parameter COUNTDOWN, default 3, meaning the pre-game countdown in seconds (0 = no countdown).
REQ-004 The block SHALL have parameter SCORE_TIMEOUT, default 10, meaning the seconds before SCORE auto-returns to IDLE (0 = wait for a click only).
REQ-005 The block SHALL have parameter RGB_W, default 12, meaning the pixel colour width.
REQ-006 The block SHALL have parameter T_W, default 8, meaning the seconds-counter width.
REQ-007 Port pclk SHALL be input, width 1: the single clock, rising edge.
REQ-008 Port rst_n SHALL be input, width 1: asynchronous, active-low reset.
REQ-009 Inputs, width 1 each: play_clicked (play rectangle click), uart_start (peer-ready pulse), pause_req (pause toggle pulse), mouse_clicked_stop (leave-score click).
REQ-010 Inputs, RGB_W each: rgb_play, rgb_wait, rgb_countdown, rgb_game, rgb_score (per-screen pixel sources).
REQ-011 Outputs: rgb_out (RGB_W, selected pixel), state (3, current state), time_left (T_W, seconds remaining), sec_tick (1, one-second strobe), game_over (1, end-of-game pulse), play_btn_en (1, play rectangle active).

Function
REQ-012 State encoding SHALL be IDLE=0, WAIT=1, COUNTDOWN=2, GAME=3, PAUSE=4, SCORE=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-013 The divider SHALL count 0..CLK_HZ-1 only in COUNTDOWN, GAME and SCORE, hold its value in PAUSE, and clear to 0 on every state change.
REQ-014 sec_tick SHALL be high for exactly one cycle, registered, in the cycle the divider equals CLK_HZ-1.
REQ-015 IDLE->WAIT SHALL occur on play_clicked.
REQ-016 A start flag SHALL set on uart_start while in WAIT and clear on any exit from WAIT.
REQ-017 WAIT SHALL advance on play_clicked when the start flag or uart_start is high in that cycle.
REQ-018 That advance SHALL go to COUNTDOWN with time_left=COUNTDOWN, or to GAME with time_left=GAME_TIME if COUNTDOWN=0.
REQ-019 In COUNTDOWN, time_left SHALL decrement on each tick; a tick at time_left=1 SHALL enter GAME with time_left=GAME_TIME.
REQ-020 In GAME, time_left SHALL decrement on each tick; a tick at time_left=1 SHALL enter SCORE with time_left=0 and game_over high for that one cycle.
REQ-021 pause_req in GAME SHALL enter PAUSE; pause_req in PAUSE SHALL return to GAME with divider and time_left unchanged.
REQ-022 pause_req in the same cycle as the final GAME tick SHALL be ignored; SCORE wins.
REQ-023 In SCORE, mouse_clicked_stop SHALL enter IDLE.
REQ-024 If SCORE_TIMEOUT>0, SCORE SHALL load time_left=SCORE_TIMEOUT on entry, decrement it per tick, and enter IDLE on a tick at time_left=1; a click in the same cycle SHALL also give IDLE.
REQ-025 time_left SHALL saturate at 0 and never wrap; GAME_TIME, COUNTDOWN and SCORE_TIMEOUT SHALL fit in T_W bits, checked by an elaboration error.
REQ-026 rgb_out SHALL be registered with one-cycle latency.
REQ-027 rgb_out selection by current state SHALL be: IDLE rgb_play, WAIT rgb_wait, COUNTDOWN rgb_countdown, GAME rgb_game, PAUSE rgb_game with every other line forced to 0, SCORE rgb_score.
REQ-028 play_btn_en SHALL be high in IDLE and WAIT only.
REQ-029 Inputs not listed for the current state SHALL be ignored.

Reset
REQ-030 While rst_n is low, outputs SHALL be: state=IDLE, rgb_out=0, time_left=0, sec_tick=0, game_over=0, play_btn_en=1, divider=0, start flag=0.
REQ-031 Reset asserted in any state, including mid-GAME or PAUSE, SHALL force these values immediately without a game_over pulse; the first post-reset edge SHALL evaluate from IDLE.

Verification (CLK_HZ=4, GAME_TIME=3, COUNTDOWN=2, SCORE_TIMEOUT=2)
REQ-032 Play click, uart_start, play click -> state 0->1->2, time_left 2,1, then GAME with time_left=3 after 8 cycles in COUNTDOWN.
REQ-033 GAME run -> time_left 3,2,1,0 on ticks every 4 cycles; game_over is a single-cycle pulse on entry to SCORE.
REQ-034 pause_req at GAME divider=2 for 10 cycles, then pause_req -> time_left unchanged and next tick 2 cycles after resume; pause_req coincident with final tick -> SCORE.
REQ-035 SCORE with no click -> IDLE after 8 cycles; a click at cycle 3 -> IDLE on the next edge.
REQ-036 rst_n low mid-GAME -> asynchronous IDLE, rgb_out=0, no game_over; rgb_out follows each state's source one cycle late, and PAUSE odd lines are 0.
REQ-037 uart_start in WAIT without a play click, then a play click 20 cycles later -> COUNTDOWN; uart_start in IDLE -> flag not set.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Screen/game-phase sequencer: IDLE -> WAIT -> COUNTDOWN -> GAME (<-> PAUSE) -> SCORE -> IDLE,
// with a one-second divider, a seconds counter and a registered per-state pixel mux.
module game_flow_ctrl #(
    parameter int unsigned CLK_HZ        = 65_000_000,
    parameter int unsigned GAME_TIME     = 60,
    parameter int unsigned COUNTDOWN     = 3,
    parameter int unsigned SCORE_TIMEOUT = 10,
    parameter int unsigned RGB_W         = 12,
    parameter int unsigned T_W           = 8
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             play_clicked,
    input  logic             uart_start,
    input  logic             pause_req,
    input  logic             mouse_clicked_stop,
    input  logic [RGB_W-1:0] rgb_play,
    input  logic [RGB_W-1:0] rgb_wait,
    input  logic [RGB_W-1:0] rgb_countdown,
    input  logic [RGB_W-1:0] rgb_game,
    input  logic [RGB_W-1:0] rgb_score,
    output logic [RGB_W-1:0] rgb_out,
    output logic [2:0]       state,
    output logic [T_W-1:0]   time_left,
    output logic             sec_tick,
    output logic             game_over,
    output logic             play_btn_en
);

    localparam int unsigned DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_HZ - 1);
    localparam longint unsigned T_LIMIT = 64'd1 << T_W;
    localparam logic [T_W-1:0] T_GAME  = T_W'(GAME_TIME);
    localparam logic [T_W-1:0] T_COUNT = T_W'(COUNTDOWN);
    localparam logic [T_W-1:0] T_SCORE = T_W'(SCORE_TIMEOUT);

    if (64'(GAME_TIME) >= T_LIMIT || 64'(COUNTDOWN) >= T_LIMIT ||
        64'(SCORE_TIMEOUT) >= T_LIMIT) begin : g_bad_t_w
        $error("game_flow_ctrl: a time parameter does not fit in T_W bits");
    end
    if (CLK_HZ == 0) begin : g_bad_clk_hz
        $error("game_flow_ctrl: CLK_HZ must be at least 1");
    end

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StWait      = 3'd1,
        StCountdown = 3'd2,
        StGame      = 3'd3,
        StPause     = 3'd4,
        StScore     = 3'd5
    } st_e;

    st_e              state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [T_W-1:0]   tl_q, tl_d, tl_dec;
    logic             sec_tick_q, sec_tick_d;
    logic             game_over_q, game_over_d;
    logic             btn_q, btn_d;
    logic             start_q, start_d;
    logic             line_q, line_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;

    function automatic logic is_counting(input st_e s);
        return (s == StCountdown) || (s == StGame) || (s == StScore);
    endfunction

    // sec_tick_q mirrors (divider == CLK_HZ-1 in a counting state), so it doubles as the tick.
    always_comb begin
        state_d = state_q;
        tl_d    = tl_q;
        tl_dec  = (tl_q != '0) ? tl_q - T_W'(1) : '0;
        case (state_q)
            StIdle: if (play_clicked) state_d = StWait;
            StWait: begin
                if (play_clicked && (start_q || uart_start)) begin
                    if (COUNTDOWN > 0) begin
                        state_d = StCountdown;
                        tl_d    = T_COUNT;
                    end else begin
                        state_d = StGame;
                        tl_d    = T_GAME;
                    end
                end
            end
            StCountdown: begin
                if (sec_tick_q) begin
                    if (tl_q <= T_W'(1)) begin
                        state_d = StGame;
                        tl_d    = T_GAME;
                    end else begin
                        tl_d = tl_dec;
                    end
                end
            end
            StGame: begin
                // The final tick beats a coincident pause request.
                if (sec_tick_q && tl_q <= T_W'(1)) begin
                    state_d = StScore;
                    tl_d    = '0;
                end else begin
                    if (sec_tick_q) tl_d = tl_dec;
                    if (pause_req) state_d = StPause;
                end
            end
            StPause: if (pause_req) state_d = StGame;
            StScore: begin
                if (mouse_clicked_stop) begin
                    state_d = StIdle;
                end else if (game_over_q) begin
                    tl_d = T_SCORE;
                end else if (sec_tick_q && SCORE_TIMEOUT > 0) begin
                    if (tl_q == T_W'(1)) state_d = StIdle;
                    else tl_d = tl_dec;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) tl_d = '0;
    end

    always_comb begin
        div_d = div_q;
        if (state_d != state_q) begin
            // Pause and resume keep the partial second; every other transition restarts it.
            if (state_q == StGame && state_d == StPause) div_d = sec_tick_q ? '0 : div_q;
            else if (state_q == StPause && state_d == StGame) div_d = div_q;
            else div_d = '0;
        end else if (is_counting(state_q)) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
        end
        sec_tick_d  = is_counting(state_d) && (div_d == DIV_MAX);
        game_over_d = (state_q == StGame) && (state_d == StScore);
        btn_d       = (state_d == StIdle) || (state_d == StWait);
        start_d     = (state_q == StWait && state_d == StWait) ? (start_q || uart_start) : 1'b0;
        line_d      = (state_q == StPause && state_d == StPause) ? ~line_q : 1'b0;
        case (state_q)
            StIdle:      rgb_d = rgb_play;
            StWait:      rgb_d = rgb_wait;
            StCountdown: rgb_d = rgb_countdown;
            StGame:      rgb_d = rgb_game;
            StPause:     rgb_d = line_q ? '0 : rgb_game;
            StScore:     rgb_d = rgb_score;
            default:     rgb_d = '0;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            tl_q        <= '0;
            sec_tick_q  <= 1'b0;
            game_over_q <= 1'b0;
            btn_q       <= 1'b1;
            start_q     <= 1'b0;
            line_q      <= 1'b0;
            rgb_q       <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            tl_q        <= tl_d;
            sec_tick_q  <= sec_tick_d;
            game_over_q <= game_over_d;
            btn_q       <= btn_d;
            start_q     <= start_d;
            line_q      <= line_d;
            rgb_q       <= rgb_d;
        end
    end

    assign state       = state_q;
    assign time_left   = tl_q;
    assign sec_tick    = sec_tick_q;
    assign game_over   = game_over_q;
    assign play_btn_en = btn_q;
    assign rgb_out     = rgb_q;

endmodule
